// File: rtl/pes_elevator_pkg.sv
// Shared types and default sizing for the elevator scheduler.
// Imported by the scheduler top and its floor picker.
package pes_elevator_pkg;

   localparam int N_FLOORS_DEF       = 8;
   localparam int DWELL_CYCLES_DEF   = 4;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      WAIT_DONE,
      DWELL,
      FAULT
   } pes_state_e;

endpackage

// File: rtl/pes_elevator_pick.sv
// SCAN floor picker: same floor first, then nearest in the sweep
// direction, otherwise reverse and take the nearest the other way.
module pes_elevator_pick
   import pes_elevator_pkg::*;
#(
   parameter int N_FLOORS = N_FLOORS_DEF
)(
   input  logic [N_FLOORS-1:0] pending,
   input  logic [N_FLOORS-1:0] current_floor,
   input  logic                dir_up,
   output logic [N_FLOORS-1:0] target,
   output logic                dir_next
);

   int                  cur_idx;
   logic [N_FLOORS-1:0] up_t;
   logic [N_FLOORS-1:0] dn_t;
   logic [N_FLOORS-1:0] here;

   always_comb begin
      cur_idx = -1;
      for (int i = 0; i < N_FLOORS; i++)
         if (current_floor[i]) cur_idx = i;

      // Later hits overwrite earlier ones, so loop order yields the nearest.
      up_t = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--)
         if (pending[i] && i > cur_idx) begin
            up_t    = '0;
            up_t[i] = 1'b1;
         end

      dn_t = '0;
      for (int i = 0; i < N_FLOORS; i++)
         if (pending[i] && i < cur_idx) begin
            dn_t    = '0;
            dn_t[i] = 1'b1;
         end

      here     = pending & current_floor;
      target   = '0;
      dir_next = dir_up;

      if (|here) begin
         target = here;
      end else if (dir_up) begin
         if (|up_t) begin
            target = up_t;
         end else if (|dn_t) begin
            target   = dn_t;
            dir_next = 1'b0;
         end
      end else begin
         if (|dn_t) begin
            target = dn_t;
         end else if (|up_t) begin
            target   = up_t;
            dir_next = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pes_elevator_scheduler.sv
// Elevator call scheduler: latches calls, dispatches one SCAN target
// at a time, holds the door for a dwell and trips a watchdog on stalls.
module pes_elevator_scheduler
   import pes_elevator_pkg::*;
#(
   parameter int N_FLOORS       = N_FLOORS_DEF,
   parameter int DWELL_CYCLES   = DWELL_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] call_req,
   input  logic [N_FLOORS-1:0] current_floor,
   input  logic                complete,
   input  logic                door_alert,
   input  logic                weight_alert,
   output logic [N_FLOORS-1:0] target_floor,
   output logic                target_valid,
   output logic [N_FLOORS-1:0] pending,
   output logic                dir_up,
   output logic                busy,
   output logic                fault
);

   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   pes_state_e          state;
   logic [WW-1:0]       wait_cnt;
   logic [DW-1:0]       dwell_cnt;
   logic [N_FLOORS-1:0] pick_target;
   logic [N_FLOORS-1:0] clr;
   logic                pick_dir;
   logic                served;
   logic                alert;

   pes_elevator_pick #(.N_FLOORS(N_FLOORS)) u_pick (
      .pending       (pending),
      .current_floor (current_floor),
      .dir_up        (dir_up),
      .target        (pick_target),
      .dir_next      (pick_dir)
   );

   assign served = (state == WAIT_DONE) && complete &&
                   (current_floor == target_floor);
   assign clr    = served ? target_floor : '0;
   assign alert  = door_alert | weight_alert;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         pending      <= '0;
         target_floor <= '0;
         target_valid <= 1'b0;
         dir_up       <= 1'b1;
         busy         <= 1'b0;
         fault        <= 1'b0;
         wait_cnt     <= '0;
         dwell_cnt    <= '0;
      end else begin
         // The served floor's clear beats a same-cycle call for it.
         pending <= (pending | call_req) & ~clr;
         unique case (state)
            IDLE: begin
               if (|pending && $onehot(current_floor)) begin
                  state <= SELECT;
                  busy  <= 1'b1;
               end
            end
            SELECT: begin
               if (|pick_target) begin
                  target_floor <= pick_target;
                  target_valid <= 1'b1;
                  dir_up       <= pick_dir;
                  wait_cnt     <= '0;
                  state        <= WAIT_DONE;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            WAIT_DONE: begin
               if (served) begin
                  target_valid <= 1'b0;
                  target_floor <= '0;
                  dwell_cnt    <= '0;
                  state        <= DWELL;
               end else if (wait_cnt == WAIT_LAST) begin
                  target_valid <= 1'b0;
                  fault        <= 1'b1;
                  state        <= FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DWELL: begin
               if (alert) begin
                  dwell_cnt <= '0;
               end else if (dwell_cnt == DWELL_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  dwell_cnt <= dwell_cnt + 1'b1;
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pes_elevator_scheduler.sv
// Directed scenarios plus randomized traffic against a floor-level
// SCAN reference model for pes_elevator_scheduler.
module tb_pes_elevator_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] call_req = 8'h00;
   logic [7:0] current_floor = 8'h01;
   logic       complete = 1'b0;
   logic       door_alert = 1'b0;
   logic       weight_alert = 1'b0;
   logic [7:0] target_floor;
   logic       target_valid;
   logic [7:0] pending;
   logic       dir_up;
   logic       busy;
   logic       fault;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pes_elevator_scheduler #(
      .N_FLOORS       (8),
      .DWELL_CYCLES   (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .call_req      (call_req),
      .current_floor (current_floor),
      .complete      (complete),
      .door_alert    (door_alert),
      .weight_alert  (weight_alert),
      .target_floor  (target_floor),
      .target_valid  (target_valid),
      .pending       (pending),
      .dir_up        (dir_up),
      .busy          (busy),
      .fault         (fault)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!target_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(target_valid), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   // Reference pick by floor distance: same floor, then nearest in the
   // sweep direction, else flip and take the nearest the other way.
   function automatic int ref_pick(input logic [7:0] p, input int c,
                                   input bit d, output bit nd);
      nd = d;
      if (c >= 0 && c < 8 && p[c]) return c;
      for (int k = 1; k < 8; k++) begin
         int f;
         f = d ? c + k : c - k;
         if (f >= 0 && f < 8 && p[f]) return f;
      end
      nd = !d;
      for (int k = 1; k < 8; k++) begin
         int f;
         f = nd ? c + k : c - k;
         if (f >= 0 && f < 8 && p[f]) return f;
      end
      nd = d;
      return -1;
   endfunction

   initial begin
      int         n;
      int         e;
      int         m_cur;
      int         m_tgt;
      int         travel;
      int         dispatches;
      bit         m_dir;
      bit         nd;
      bit         m_wait;
      bit         tv_prev;
      logic [7:0] m_pend;
      logic [7:0] snap;
      logic [7:0] call;

      // Reset with calls present: calls must be ignored.
      reset    = 1'b0;
      call_req = 8'hFF;
      repeat (2) tick();
      chk("rst_pend", 32'(pending), 32'h00);
      chk("rst_tf", 32'(target_floor), 32'h00);
      chk("rst_tv", 32'(target_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_dir", 32'(dir_up), 32'd1);
      reset    = 1'b1;
      call_req = 8'h00;
      tick();

      // Single trip 0x01 -> 0x10.
      call_req = 8'h10;
      tick();
      call_req = 8'h00;
      chk("t1_pend", 32'(pending), 32'h10);
      chk("t1_tv0", 32'(target_valid), 32'd0);
      tick();
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_tv1", 32'(target_valid), 32'd0);
      tick();
      chk("t1_tv2", 32'(target_valid), 32'd1);
      chk("t1_tf", 32'(target_floor), 32'h10);
      chk("t1_dir", 32'(dir_up), 32'd1);
      tick();
      chk("t1_hold_tf", 32'(target_floor), 32'h10);
      chk("t1_hold_tv", 32'(target_valid), 32'd1);
      current_floor = 8'h10;
      complete      = 1'b1;
      tick();
      complete = 1'b0;
      chk("t1_clr", 32'(pending), 32'h00);
      chk("t1_tv_off", 32'(target_valid), 32'd0);
      n = 0;
      while (busy && n < 30) begin
         tick();
         n++;
      end
      chk("t1_dwell", 32'(n), 32'd4);

      // SCAN reversal from floor 3 with calls at 6 and 0.
      current_floor = 8'h08;
      call_req      = 8'h41;
      tick();
      call_req = 8'h00;
      wait_valid("t2_wait1");
      chk("t2_tf1", 32'(target_floor), 32'h40);
      chk("t2_dir1", 32'(dir_up), 32'd1);
      current_floor = 8'h40;
      complete      = 1'b1;
      tick();
      complete = 1'b0;
      chk("t2_pend", 32'(pending), 32'h01);
      wait_valid("t2_wait2");
      chk("t2_tf2", 32'(target_floor), 32'h01);
      chk("t2_dir2", 32'(dir_up), 32'd0);
      current_floor = 8'h01;
      complete      = 1'b1;
      tick();
      complete = 1'b0;
      wait_idle("t2_idle");

      // Weight alert held for the first 10 dwell cycles.
      call_req = 8'h01;
      tick();
      call_req = 8'h00;
      wait_valid("t3_wait");
      chk("t3_tf", 32'(target_floor), 32'h01);
      complete = 1'b1;
      tick();
      complete     = 1'b0;
      weight_alert = 1'b1;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
         if (n == 10) weight_alert = 1'b0;
      end
      weight_alert = 1'b0;
      chk("t3_dwell", 32'(n), 32'd14);

      // Served-floor call in the completion cycle, then reset mid-trip.
      call_req = 8'h20;
      tick();
      call_req = 8'h00;
      wait_valid("t4_wait1");
      chk("t4_tf1", 32'(target_floor), 32'h20);
      chk("t4_dir1", 32'(dir_up), 32'd1);
      current_floor = 8'h20;
      complete      = 1'b1;
      call_req      = 8'h22;
      tick();
      complete = 1'b0;
      call_req = 8'h00;
      chk("t4_clrwin", 32'(pending), 32'h02);
      wait_valid("t4_wait2");
      chk("t4_tf2", 32'(target_floor), 32'h02);
      chk("t4_dir2", 32'(dir_up), 32'd0);
      call_req = 8'h80;
      tick();
      reset = 1'b0;
      tick();
      chk("t4_rst_tv", 32'(target_valid), 32'd0);
      chk("t4_rst_pend", 32'(pending), 32'h00);
      chk("t4_rst_busy", 32'(busy), 32'd0);
      chk("t4_rst_dir", 32'(dir_up), 32'd1);
      reset    = 1'b1;
      call_req = 8'h00;
      tick();
      chk("t4_post_busy", 32'(busy), 32'd0);

      // Watchdog: dispatch to floor 3 and never complete.
      current_floor = 8'h01;
      call_req      = 8'h08;
      tick();
      call_req = 8'h00;
      wait_valid("t5_wait");
      chk("t5_tf", 32'(target_floor), 32'h08);
      n = 0;
      while (!fault && n < 100) begin
         tick();
         n++;
      end
      chk("t5_to_cycles", 32'(n), 32'd64);
      chk("t5_tv", 32'(target_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      call_req = 8'h02;
      tick();
      call_req = 8'h00;
      chk("t5_pend", 32'(pending), 32'h0A);
      current_floor = 8'h08;
      complete      = 1'b1;
      tick();
      complete = 1'b0;
      repeat (5) tick();
      chk("t5_sticky", 32'(fault), 32'd1);
      chk("t5_sticky_tv", 32'(target_valid), 32'd0);
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      chk("t5_rst_fault", 32'(fault), 32'd0);
      chk("t5_rst_pend", 32'(pending), 32'h00);

      // Randomized traffic with the bench acting as the car.
      current_floor = 8'h01;
      tick();
      m_pend     = 8'h00;
      m_dir      = 1'b1;
      m_cur      = 0;
      m_tgt      = 0;
      m_wait     = 1'b0;
      travel     = 0;
      tv_prev    = 1'b0;
      dispatches = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc >= 3000 && m_pend == 8'h00 && !m_wait && !busy) break;
         call = 8'h00;
         if (cyc < 3000 && $urandom_range(0, 3) == 0)
            call = 8'(32'd1 << $urandom_range(0, 7));
         call_req   = call;
         door_alert = (cyc < 3000) && ($urandom_range(0, 7) == 0);
         complete   = 1'b0;
         if (m_wait) begin
            if (travel == 0) travel = $urandom_range(1, 6);
            travel--;
            if (travel == 0) begin
               m_cur         = m_tgt;
               current_floor = 8'(32'd1 << m_tgt);
               complete      = 1'b1;
            end
         end
         snap = m_pend;
         tick();
         m_pend = m_pend | call;
         if (complete) begin
            m_pend[m_tgt] = 1'b0;
            m_wait        = 1'b0;
         end
         chk("rnd_pend", 32'(pending), 32'(m_pend));
         if (target_valid && !tv_prev) begin
            e = ref_pick(snap, m_cur, m_dir, nd);
            chk("rnd_tgt", 32'(target_floor), (e < 0) ? 32'd0 : (32'd1 << e));
            chk("rnd_dir", 32'(dir_up), 32'(nd));
            m_dir  = nd;
            m_tgt  = (e < 0) ? 0 : e;
            m_wait = 1'b1;
            travel = 0;
            dispatches++;
         end
         tv_prev = target_valid;
      end
      call_req   = 8'h00;
      door_alert = 1'b0;
      complete   = 1'b0;
      chk("rnd_drained", 32'(m_pend), 32'h00);
      chk("rnd_busy", 32'(busy), 32'd0);
      chk("rnd_fault", 32'(fault), 32'd0);
      chk("rnd_trips", 32'(dispatches > 50), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pes_elevator_scheduler.md
PES_ELEVATOR_SCHEDULER -- requirements
Module: pes_elevator_scheduler

Interface
REQ-001 SHALL have parameter N_FLOORS, default 8: number of floors, one-hot floor width.
REQ-002 SHALL have parameter DWELL_CYCLES, default 4: door-open dwell length in clk cycles.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit for one trip.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port call_req, input, N_FLOORS: per-floor call pulses (hall or cab).
REQ-007 SHALL have port current_floor, input, N_FLOORS: one-hot car position from the elevator.
REQ-008 SHALL have port complete, input, 1: elevator arrived at the requested floor.
REQ-009 SHALL have ports door_alert and weight_alert, input, 1 each: car alerts.
REQ-010 SHALL have port target_floor, output, N_FLOORS: one-hot floor dispatched to the elevator.
REQ-011 SHALL have port target_valid, output, 1: target_floor is meaningful.
REQ-012 SHALL have port pending, output, N_FLOORS: registered outstanding calls.
REQ-013 SHALL have port dir_up, output, 1: SCAN sweep direction, 1 = up.
REQ-014 SHALL have ports busy and fault, output, 1 each: not IDLE; watchdog expired.

Function
REQ-015 SHALL implement the FSM states IDLE, SELECT, WAIT_DONE, DWELL and FAULT.
REQ-016 SHALL OR each call_req bit into pending every cycle, in all states including FAULT.
REQ-017 SHALL move IDLE->SELECT when pending is nonzero and current_floor is exactly one-hot; a zero or multi-hot current_floor holds IDLE.
REQ-018 SHALL compute the target in SELECT in one cycle, load target_floor, assert target_valid and enter WAIT_DONE on the next edge.
REQ-019 SHALL select a pending bit equal to current_floor first.
REQ-020 SHALL otherwise select the nearest pending floor in the dir_up direction.
REQ-021 SHALL, when no pending floor lies in the dir_up direction, invert dir_up and select the nearest pending floor in the new direction.
REQ-022 SHALL hold target_floor and target_valid stable throughout WAIT_DONE.
REQ-023 SHALL leave WAIT_DONE for DWELL when complete=1 and current_floor==target_floor; in the same edge it clears that pending bit and deasserts target_valid.
REQ-024 SHALL let the clear win over a same-cycle call_req for the floor being served; set wins for all other bits.
REQ-025 SHALL count DWELL_CYCLES in DWELL, reload the count while door_alert or weight_alert is 1, then return to IDLE.
REQ-026 SHALL count WAIT_DONE cycles and enter FAULT when TIMEOUT_CYCLES is reached without completion; in FAULT, fault=1 and target_valid=0.
REQ-027 SHALL keep FAULT sticky until reset.
REQ-028 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-029 SHALL, when reset=0 at a clk edge, force IDLE, pending=0, target_floor=0, target_valid=0, dir_up=1, busy=0, fault=0 and clear all counters, including mid-trip.
REQ-030 SHALL ignore call_req in a reset cycle.

Structure
REQ-031 SHALL place the state enumeration and the default N_FLOORS, DWELL_CYCLES and TIMEOUT_CYCLES constants in a shared package pes_elevator_pkg.
REQ-032 SHALL implement the nearest-floor search as one combinational sub-module pes_elevator_pick(pending, current_floor, dir_up -> target, dir_next).
REQ-033 SHALL be reusable in front of pes_elevator, with target_floor driving request_floor.

Verification
REQ-034 SHALL verify: reset=0 for two cycles -> all outputs zero, dir_up=1.
REQ-035 SHALL verify: current=8'h01, call_req=8'h10 pulse -> target_floor=8'h10 and target_valid=1 two cycles later; complete with current=8'h10 -> pending=0, DWELL for 4 cycles, then IDLE.
REQ-036 SHALL verify: current=8'h08, dir_up=1, pending=8'h41 -> targets served in order 8'h40 then 8'h01, with dir_up going 0 before the second dispatch.
REQ-037 SHALL verify: weight_alert=1 for 10 cycles during DWELL -> DWELL lasts 14 cycles.
REQ-038 SHALL verify: no complete for 64 cycles -> fault=1, target_valid=0; later call_req=8'h02 -> pending bit set, FSM stays in FAULT until reset.
REQ-039 SHALL verify: reset=0 during WAIT_DONE -> IDLE on the next edge with pending=0; call_req on the served floor in the completion cycle -> pending bit stays 0.
